mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 2, cycles from request acceptance to response; legal range 1..15.
REQ-002 Parameter ADDR_BITS, default 6, word-index width; storage depth is 2**ADDR_BITS 32-bit words.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  1  initiator (control unit / datapath) presents a memory request.
REQ-006 memRW  input  1  request type: 0 = read, 1 = write.
REQ-007 addr  input  32  byte address from the Iord-selected source.
REQ-008 wdata  input  32  write data, sampled only at acceptance of a write.
REQ-009 req_ready  output  1  responder idle and able to accept a request.
REQ-010 rsp_valid  output  1  one-cycle pulse marking completion of the accepted request.
REQ-011 rdata  output  32  read data, valid when rsp_valid is high for a read; otherwise holds last read value.
REQ-012 err  output  1  one-cycle pulse, coincident with rsp_valid, flagging a misaligned request.

Function
REQ-013 The block SHALL implement a 3-state FSM: IDLE, WAIT, RESP.
REQ-014 IDLE: req_ready=1; on req_valid=1 SHALL capture memRW, addr, wdata into request registers (acceptance cycle T).
REQ-015 From IDLE on acceptance: LATENCY=1 -> RESP; LATENCY>1 -> WAIT with a down-counter loaded to LATENCY-2.
REQ-016 WAIT: req_ready=0; counter decrements each cycle; at counter=0 SHALL move to RESP.
REQ-017 RESP: rsp_valid=1 for exactly one cycle, at cycle T+LATENCY; next state IDLE unconditionally.
REQ-018 req_ready SHALL be 0 in WAIT and RESP; req_valid asserted then SHALL be ignored, with no capture or side effect.
REQ-019 Word index SHALL be addr[ADDR_BITS+1:2]; higher address bits ignored (aliasing wrap-around, no error).
REQ-020 Misaligned request (captured addr[1:0] != 0) SHALL complete with normal timing, err=1 with rsp_valid, no storage write, rdata unchanged.
REQ-021 Aligned write SHALL update the indexed word in the RESP cycle; the write is visible to a read accepted at the earliest next acceptance (T+LATENCY+1).
REQ-022 Aligned read SHALL drive the indexed word onto rdata registered so rdata is valid in the RESP cycle.
REQ-023 Aligned write SHALL leave rdata unchanged.
REQ-024 Maximum throughput SHALL be one request per LATENCY+1 cycles; back-to-back req_valid holding high is accepted at T, T+LATENCY+1, ...
REQ-025 Request registers SHALL hold captured values until the next acceptance; changes on addr/wdata/memRW after T SHALL have no effect.
REQ-026 Storage SHALL be a synchronous-write array of 2**ADDR_BITS words, not cleared by reset.

Reset
REQ-027 With rst=0 at a rising edge: state=IDLE, counter=0, req_ready=1, rsp_valid=0, err=0, rdata=32'h0000_0000.
REQ-028 Reset mid-operation (WAIT or RESP) SHALL abort the request: no rsp_valid, no err, and a pending write not yet in RESP SHALL NOT be committed.
REQ-029 Reset asserted during a RESP-cycle write SHALL NOT commit the write (reset has priority).
REQ-030 First acceptance after reset SHALL be possible in the cycle rst returns to 1.

Verification
REQ-031 LATENCY=2: write addr=0x10, wdata=0xDEADBEEF at T -> rsp_valid=1, err=0 at T+2 only; req_ready=0 at T+1,T+2, 1 at T+3.
REQ-032 Then read addr=0x10 at T+3 -> rsp_valid=1 at T+5 with rdata=0xDEADBEEF; rdata holds 0xDEADBEEF after.
REQ-033 Alias: ADDR_BITS=6, write 0x12345678 to addr=0x104, read addr=0x004 -> rdata=0x12345678, err=0.
REQ-034 Misaligned: write 0xFFFFFFFF to addr=0x12, then read addr=0x10 -> first response err=1; read returns previous contents (0xDEADBEEF).
REQ-035 Reset mid-op: write 0xAAAA5555 to addr=0x20, rst=0 at T+1 for one cycle -> no rsp_valid, req_ready=1 and rdata=0 after reset; read addr=0x20 returns original contents.
REQ-036 Sweep LATENCY=1 and 15 with req_valid held high continuously -> acceptances spaced exactly LATENCY+1 cycles, one rsp_valid per acceptance.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port word memory behind a request/response handshake with a fixed,
// parameterised response latency and misaligned-access reporting.
module mem_responder #(
    parameter int LATENCY   = 2,
    parameter int ADDR_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        memRW,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int         DEPTH      = 1 << ADDR_BITS;
    localparam int         LOW_BITS   = ADDR_BITS + 2;
    localparam bit         SINGLE_CYC = (LATENCY == 1);
    localparam logic [3:0] WAIT_LOAD  = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           rdata_q, rdata_d;

    logic                  rw_q, rw_d;
    logic [LOW_BITS-1:0]   addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;

    logic [31:0]           mem_q [DEPTH];

    logic                  enter_resp;
    logic                  cur_rw;
    logic [LOW_BITS-1:0]   cur_addr;
    logic                  mem_we;
    logic                  unused_addr_hi;

    // Bits above the word index alias onto the same storage and are dropped.
    assign unused_addr_hi = ^addr[31:LOW_BITS];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        enter_resp = 1'b0;
        cur_rw     = rw_q;
        cur_addr   = addr_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    rw_d     = memRW;
                    addr_d   = addr[LOW_BITS-1:0];
                    wdata_d  = wdata;
                    cur_rw   = memRW;
                    cur_addr = addr[LOW_BITS-1:0];
                    if (SINGLE_CYC) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Read data is fetched on the edge into RESP so it is already registered there.
        if (enter_resp && !cur_rw && (cur_addr[1:0] == 2'b00)) begin
            rdata_d = mem_q[cur_addr[LOW_BITS-1:2]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Request registers carry data only; the state register decides when they matter.
    always_ff @(posedge clk) begin
        rw_q    <= rw_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign mem_we = rst && (state_q == ST_RESP) && rw_q && (addr_q[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q[LOW_BITS-1:2]] <= wdata_q;
        end
    end

    // Response pulses are suppressed while reset is asserted so an aborted request never completes.
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rst && (state_q == ST_RESP);
    assign err       = rsp_valid && (addr_q[1:0] != 2'b00);
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: cycle-level reference model for the
// LATENCY=2 instance plus throughput sweeps on LATENCY=1 and LATENCY=15 instances.
module tb_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, memRW;
    logic [31:0] addr, wdata;
    logic        req_ready, rsp_valid, err;
    logic [31:0] rdata;

    logic        sw_valid;
    logic        sw_rw    = 1'b1;
    logic [31:0] sw_addr  = 32'h0;
    logic [31:0] sw_wdata = 32'hC0FF_EE00;
    logic        r1_ready, r1_rsp, r1_err;
    logic [31:0] r1_rdata;
    logic        r15_ready, r15_rsp, r15_err;
    logic [31:0] r15_rdata;

    int nvec  = 0;
    int nfail = 0;
    int cyc   = 0;
    bit chk_en = 0;
    bit sw_en  = 0;

    always #5 clk = ~clk;

    mem_responder #(.LATENCY(LAT), .ADDR_BITS(6)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .memRW(memRW), .addr(addr),
        .wdata(wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rdata(rdata), .err(err)
    );

    mem_responder #(.LATENCY(1), .ADDR_BITS(6)) dut_l1 (
        .clk(clk), .rst(rst), .req_valid(sw_valid), .memRW(sw_rw), .addr(sw_addr),
        .wdata(sw_wdata), .req_ready(r1_ready), .rsp_valid(r1_rsp), .rdata(r1_rdata), .err(r1_err)
    );

    mem_responder #(.LATENCY(15), .ADDR_BITS(6)) dut_l15 (
        .clk(clk), .rst(rst), .req_valid(sw_valid), .memRW(sw_rw), .addr(sw_addr),
        .wdata(sw_wdata), .req_ready(r15_ready), .rsp_valid(r15_rsp), .rdata(r15_rdata), .err(r15_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a request occupies the responder for LAT cycles after acceptance,
    // completes in the last of them, and is wiped out by any reset edge before commit.
    bit          m_busy   = 0;
    int          m_left   = 0;
    bit          m_rw;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata  = 32'h0;
    bit          m_rknown = 0;
    logic [31:0] m_mem   [64];
    bit          m_known [64];

    task model_enter_resp();
        if (!m_rw && m_addr[1:0] == 2'b00) begin
            if (m_known[m_addr[7:2]]) m_rdata = m_mem[m_addr[7:2]];
            else m_rknown = 0;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            m_busy = 0; m_rdata = 32'h0; m_rknown = 1;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy = 1; m_rw = memRW; m_addr = addr; m_wdata = wdata; m_left = LAT - 1;
                if (m_left == 0) model_enter_resp();
            end
        end else if (m_left == 0) begin
            if (m_rw && m_addr[1:0] == 2'b00) begin
                m_mem[m_addr[7:2]] = m_wdata;
                m_known[m_addr[7:2]] = 1;
            end
            m_busy = 0;
        end else begin
            m_left--;
            if (m_left == 0) model_enter_resp();
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_rsp;
            exp_rsp = m_busy && (m_left == 0) && rst;
            chk("cyc_req_ready", {31'b0, req_ready}, {31'b0, !m_busy});
            chk("cyc_rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_rsp});
            chk("cyc_err", {31'b0, err}, {31'b0, exp_rsp && (m_addr[1:0] != 2'b00)});
            if (m_rknown) chk("cyc_rdata", rdata, m_rdata);
        end
    end

    // Throughput sweep monitor for the LATENCY=1 and LATENCY=15 instances.
    int acc1 = 0, rsp1 = 0, last1 = -1;
    int acc15 = 0, rsp15 = 0, last15 = -1;

    always @(negedge clk) begin
        if (sw_en) begin
            if (r1_ready && sw_valid) begin
                if (last1 >= 0) chk("l1_spacing", cyc - last1, 2);
                last1 = cyc; acc1++;
            end
            if (r1_rsp) begin
                chk("l1_latency", cyc - last1, 1);
                chk("l1_err", {31'b0, r1_err}, 32'h0);
                rsp1++;
            end
            if (r15_ready && sw_valid) begin
                if (last15 >= 0) chk("l15_spacing", cyc - last15, 16);
                last15 = cyc; acc15++;
            end
            if (r15_rsp) begin
                chk("l15_latency", cyc - last15, 15);
                chk("l15_err", {31'b0, r15_err}, 32'h0);
                rsp15++;
            end
        end
    end

    task automatic issue(input bit rw, input logic [31:0] a, input logic [31:0] d, input bit hold,
                         output int lat, output logic e, output logic [31:0] rd);
        req_valid = 1; memRW = rw; addr = a; wdata = d;
        @(posedge clk); #1;
        // Inputs move after acceptance; with hold a competing write stays asserted.
        memRW     = hold ? 1'b1 : ~rw;
        addr      = hold ? 32'h30 : $urandom;
        wdata     = hold ? 32'h9999_9999 : $urandom;
        req_valid = hold;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        req_valid = 0;
        e = err; rd = rdata;
        @(posedge clk); #1;
    endtask

    task automatic xact(input string name, input bit rw, input logic [31:0] a, input logic [31:0] d,
                        input bit hold, input logic exp_err, input logic [31:0] exp_rd);
        int lat; logic e; logic [31:0] rd;
        issue(rw, a, d, hold, lat, e, rd);
        chk({name, "_latency"}, lat, LAT);
        chk({name, "_err"}, {31'b0, e}, {31'b0, exp_err});
        chk({name, "_rdata"}, rd, exp_rd);
        chk({name, "_ready_after"}, {31'b0, req_ready}, 32'h1);
    endtask

    initial begin
        int nrsp;
        rst = 0; req_valid = 0; memRW = 0; addr = 0; wdata = 0; sw_valid = 0;
        for (int i = 0; i < 64; i++) m_known[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1; chk_en = 1;
        chk("reset_ready", {31'b0, req_ready}, 32'h1);
        chk("reset_rsp", {31'b0, rsp_valid}, 32'h0);
        chk("reset_err", {31'b0, err}, 32'h0);
        chk("reset_rdata", rdata, 32'h0);

        // Accepted in the very cycle reset is released.
        xact("wr_10", 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 32'h0);
        xact("rd_10", 0, 32'h10, 32'h0, 0, 0, 32'hDEAD_BEEF);
        chk("rd_10_hold", rdata, 32'hDEAD_BEEF);

        xact("wr_alias", 1, 32'h104, 32'h1234_5678, 0, 0, 32'hDEAD_BEEF);
        xact("rd_alias", 0, 32'h004, 32'h0, 0, 0, 32'h1234_5678);

        xact("wr_misal", 1, 32'h12, 32'hFFFF_FFFF, 0, 1, 32'h1234_5678);
        xact("rd_after_misal", 0, 32'h10, 32'h0, 0, 0, 32'hDEAD_BEEF);
        xact("rd_misal", 0, 32'h13, 32'h0, 0, 1, 32'hDEAD_BEEF);

        // A write asserted while busy must be ignored.
        xact("wr_30", 1, 32'h30, 32'h3030_3030, 0, 0, 32'hDEAD_BEEF);
        xact("wr_34_hold", 1, 32'h34, 32'h3434_3434, 1, 0, 32'hDEAD_BEEF);
        xact("rd_30", 0, 32'h30, 32'h0, 0, 0, 32'h3030_3030);
        xact("rd_34", 0, 32'h34, 32'h0, 0, 0, 32'h3434_3434);

        // Reset during WAIT aborts a pending write.
        xact("wr_20", 1, 32'h20, 32'h1111_2222, 0, 0, 32'h3434_3434);
        req_valid = 1; memRW = 1; addr = 32'h20; wdata = 32'hAAAA_5555;
        @(posedge clk); #1;
        req_valid = 0; rst = 0;
        @(posedge clk); #1;
        rst = 1;
        chk("abort_ready", {31'b0, req_ready}, 32'h1);
        chk("abort_rdata", rdata, 32'h0);
        nrsp = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) nrsp++;
            @(posedge clk); #1;
        end
        chk("abort_no_rsp", nrsp, 0);
        xact("rd_20", 0, 32'h20, 32'h0, 0, 0, 32'h1111_2222);

        // Reset in the RESP cycle of a write blocks the commit and the pulse.
        xact("wr_24", 1, 32'h24, 32'h3333_4444, 0, 0, 32'h1111_2222);
        req_valid = 1; memRW = 1; addr = 32'h24; wdata = 32'h5555_6666;
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #1;
        rst = 0;
        #1;
        chk("resp_reset_no_rsp", {31'b0, rsp_valid}, 32'h0);
        chk("resp_reset_no_err", {31'b0, err}, 32'h0);
        @(posedge clk); #1;
        rst = 1;
        xact("rd_24", 0, 32'h24, 32'h0, 0, 0, 32'h3333_4444);

        // Continuous req_valid on the LATENCY=1 and LATENCY=15 instances for 100 cycles.
        sw_valid = 1; sw_en = 1;
        repeat (100) @(posedge clk);
        #1;
        sw_en = 0; sw_valid = 0;
        chk("l1_accepts", acc1, 50);
        chk("l1_responses", rsp1, 50);
        chk("l15_accepts", acc15, 7);
        chk("l15_responses", rsp15, 6);
        chk("l1_rdata_kept", r1_rdata, 32'h0);
        chk("l15_rdata_kept", r15_rdata, 32'h0);

        repeat (20) @(posedge clk);
        #1;
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
